// File: rtl/jk_flipflop.sv
// Bank of independent JK flip-flops with a true and a complementary output.
// Reset is asynchronous and active-low and loads RESET_VALUE.
module jk_flipflop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] q_next;

  // Per-bit JK truth table: 00 hold, 01 reset, 10 set, 11 toggle.
  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({j[i], k[i]})
        2'b00:   q_next[i] = q[i];
        2'b01:   q_next[i] = 1'b0;
        2'b10:   q_next[i] = 1'b1;
        default: q_next[i] = ~q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RESET_VALUE;
    else        q <= q_next;
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_jk_flipflop.sv
// Directed bench for jk_flipflop: a 1-bit default instance and a 4-bit
// instance with a non-zero reset value share clock and reset.
module tb_jk_flipflop;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       j_a, k_a, q_a, qb_a;
  logic [3:0] j_b, k_b, q_b, qb_b;

  int n_checks = 0;
  int n_pass   = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic j;
    logic k;
    logic exp;
  } vec_t;

  vec_t vecs[12];

  jk_flipflop u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (j_a),
    .k     (k_a),
    .q     (q_a),
    .q_bar (qb_a)
  );

  jk_flipflop #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (j_b),
    .k     (k_b),
    .q     (q_b),
    .q_bar (qb_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_a(input string name, input logic exp);
    check({name, ".q"},     {3'b0, q_a},  {3'b0, exp});
    check({name, ".q_bar"}, {3'b0, qb_a}, {3'b0, ~exp});
  endtask

  // Drive J/K away from the active edge, then sample 1 time unit after it.
  task automatic step_a(input logic jv, input logic kv);
    @(negedge clk);
    j_a = jv;
    k_a = kv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    j_a = 1'b0; k_a = 1'b0; j_b = 4'b0; k_b = 4'b0;

    // Reset held from time 0 with the clock running and random J/K.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      j_a = 1'($urandom_range(0, 1));
      k_a = 1'($urandom_range(0, 1));
      j_b = 4'($urandom_range(0, 15));
      k_b = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check_a("rst_hold_a", 1'b0);
      check("rst_hold_b.q",     q_b,  4'b1010);
      check("rst_hold_b.q_bar", qb_b, 4'b0101);
    end

    // Release between edges; wide bank: bit0 toggle, bit1 set, bit2 reset, bit3 hold.
    @(negedge clk);
    rst_n = 1'b1;
    j_a = 1'b0; k_a = 1'b0;
    j_b = 4'b0011; k_b = 4'b0101;
    @(posedge clk);
    #1;
    check("wide_mix.q",     q_b,  4'b1011);
    check("wide_mix.q_bar", qb_b, 4'b0100);
    check_a("first_edge_hold", 1'b0);

    step_a(1'b0, 1'b0);
    j_b = 4'b1111; k_b = 4'b1111;
    @(posedge clk);
    #1;
    check("wide_toggle.q", q_b, 4'b0101);
    j_b = 4'b0000; k_b = 4'b0000;

    // Table-driven single-bit sequence.
    for (int i = 0; i < 12; i++) begin
      step_a(vecs[i].j, vecs[i].k);
      exp_q.push_back(vecs[i].exp);
      check_a($sformatf("vec%0d", i), exp_q.pop_front());
    end
    check("wide_hold.q", q_b, 4'b0101);

    // Continuous toggle from q = 0 divides the clock by two.
    for (int i = 0; i < 8; i++) begin
      step_a(1'b1, 1'b1);
      check_a($sformatf("div2_%0d", i), (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Asynchronous reset between edges with q = 1.
    step_a(1'b1, 1'b0);
    check_a("pre_async", 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 1'b0);
    check("async_rst_b.q", q_b, 4'b1010);
    @(posedge clk);
    #1;
    check_a("rst_ignores_set", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_a("set_after_release", 1'b1);

    // Reset asserted on a rising edge wins over a set.
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check_a("rst_on_edge", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    j_a = 1'b1; k_a = 1'b1;
    @(posedge clk);
    #1;
    check_a("toggle_after_rst", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
